// File: rtl/rr_line_arbiter.sv
// ---------------------------------------------------------------------------
// rr_line_arbiter
//
// Round-robin arbiter and sequencer for the four-line scan datapath. It grants
// one of four requesters at a time and holds that grant for a bounded number
// of cycles. While a grant is active, the granted data line is routed onto a
// single registered output. The downstream one-hot line decoder/latch stage
// consumes grant and dout directly.
//
// Parameters
//   HOLD_W     width of hold_len and of the internal hold counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request levels, bit i = requester i
//   din[3:0]   data lines, bit i = line i
//   done       release pulse from the currently granted requester
//   hold_len   maximum grant length in cycles, sampled at grant (0 = unlimited)
//   grant[3:0] registered one-hot grant, 0 when idle
//   sel[1:0]   registered index of the current or last grant
//   busy       registered, high while a grant is active
//   dout       registered din[sel] while busy, else 0
//   rel_pulse  one-cycle pulse on the cycle after a grant ends
//   rel_cause  cause of the last release: 01 done, 10 request dropped,
//              11 hold timeout; holds until the next release
// ---------------------------------------------------------------------------
module rr_line_arbiter #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [3:0]        din,
  input  logic              done,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              dout,
  output logic              rel_pulse,
  output logic [1:0]        rel_cause
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_DONE = 2'b01;
  localparam logic [1:0] CAUSE_DROP = 2'b10;
  localparam logic [1:0] CAUSE_HOLD = 2'b11;

  state_t            state_reg;
  logic [1:0]        ptr_reg;
  logic [1:0]        sel_reg;
  logic [3:0]        grant_reg;
  logic              busy_reg;
  logic              dout_reg;
  logic              rel_pulse_reg;
  logic [1:0]        rel_cause_reg;
  logic [HOLD_W-1:0] cnt_reg;
  logic [HOLD_W-1:0] hold_q_reg;

  // -------------------------------------------------------------------------
  // Round-robin winner search.
  // Candidate k is requester ptr+1+k (mod 4). Candidate 0 therefore follows
  // the last winner, and candidate 3 is the last winner itself.
  // -------------------------------------------------------------------------
  logic [1:0] cand_idx [4];
  logic [3:0] cand_req;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;
  logic       win_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = ptr_reg + 2'(gi + 1);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // The loop runs from the lowest to the highest priority candidate, so the
  // last assignment made belongs to the first asserted candidate.
  always_comb begin
    win_idx = cand_idx[3];
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  assign win_valid = |req;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 2'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Release conditions while a grant is active.
  // The hold timeout fires when the counter reaches hold_q-1. Because the
  // counter starts at 0 on the grant edge, a grant with hold_q = H lasts
  // exactly H cycles. When hold_q is 0 the timeout is disabled, and the
  // saturated counter never produces a release.
  // -------------------------------------------------------------------------
  logic       rel_done;
  logic       rel_drop;
  logic       rel_hold;
  logic       release_now;
  logic [1:0] cause_next;

  assign rel_done    = done;
  assign rel_drop    = ~req[sel_reg];
  assign rel_hold    = (hold_q_reg != '0) &&
                       (cnt_reg == hold_q_reg - HOLD_W'(1));
  assign release_now = rel_done | rel_drop | rel_hold;

  // When several release conditions hold at once, done outranks a dropped
  // request, and a dropped request outranks the hold timeout.
  always_comb begin
    cause_next = CAUSE_HOLD;
    if (rel_done) begin
      cause_next = CAUSE_DONE;
    end else if (rel_drop) begin
      cause_next = CAUSE_DROP;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered here.
  // Reset during a grant aborts it outright, so reset never produces a
  // release pulse and never updates the release cause.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd3;   // requester 0 searched first after reset
      sel_reg       <= 2'd0;
      grant_reg     <= 4'b0000;
      busy_reg      <= 1'b0;
      dout_reg      <= 1'b0;
      rel_pulse_reg <= 1'b0;
      rel_cause_reg <= 2'b00;
      cnt_reg       <= '0;
      hold_q_reg    <= '0;
    end else begin
      rel_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          grant_reg <= 4'b0000;
          busy_reg  <= 1'b0;
          dout_reg  <= 1'b0;
          if (win_valid) begin
            state_reg  <= GRANT;
            sel_reg    <= win_idx;
            ptr_reg    <= win_idx;
            grant_reg  <= win_onehot;
            busy_reg   <= 1'b1;
            dout_reg   <= din[win_idx];
            hold_q_reg <= hold_len;
            cnt_reg    <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_reg     <= IDLE;
            grant_reg     <= 4'b0000;
            busy_reg      <= 1'b0;
            dout_reg      <= 1'b0;
            rel_pulse_reg <= 1'b1;
            rel_cause_reg <= cause_next;
          end else begin
            if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + HOLD_W'(1);
            end
            dout_reg <= din[sel_reg];
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_reg;
  assign sel       = sel_reg;
  assign busy      = busy_reg;
  assign dout      = dout_reg;
  assign rel_pulse = rel_pulse_reg;
  assign rel_cause = rel_cause_reg;

endmodule

// File: doc/rr_line_arbiter.md
# rr_line_arbiter

Round-robin arbiter and sequencer for the four-line scan datapath. Instead of a free-running select counter, it grants one of four requesters at a time, holds the grant for a bounded number of cycles, and routes the granted line onto a single registered data output. It sits between the four line sources and the one-hot line decoder/latch stage, which consumes `grant` and `dout` directly.

## Interface
- `HOLD_W`, 4: width of the hold-length input and internal hold counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low. Single clock domain.
- `req`  in  4  per-requester request levels, bit i = requester i.
- `din`  in  4  per-requester data lines, bit i = line i.
- `done`  in  1  release pulse from the currently granted requester.
- `hold_len`  in  HOLD_W  maximum grant length in cycles, sampled at grant. 0 = unlimited.
- `grant`  out  4  registered one-hot grant. 0 when idle.
- `sel`  out  2  registered binary index of the current or last grant.
- `busy`  out  1  registered. High while in GRANT.
- `dout`  out  1  registered. `din[sel]` while busy, else 0.
- `rel_pulse`  out  1  one-cycle pulse on the cycle after a grant ends.
- `rel_cause`  out  2  registered cause of the last release: 01 = done, 10 = request dropped, 11 = hold timeout. Holds its value until the next release.

## Operation
- States:
  - IDLE: `grant` = 0, `busy` = 0.
  - GRANT: `grant` = one-hot(`sel`), `busy` = 1.
- Priority pointer `ptr` (2 bits) holds the last winner. The search order is `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4). The first asserted `req` bit in that order wins.
- IDLE -> GRANT: at an edge where `|req`.
  - Load `sel` and `ptr` with the winner.
  - Set `grant` to one-hot(winner) and `busy` = 1.
  - Capture `hold_len` into `hold_q` and clear `cnt` to 0.
- In GRANT, `cnt` increments each cycle and saturates at all-ones.
- GRANT -> IDLE at an edge where any of these hold:
  - (a) `done` = 1;
  - (b) `req[sel]` = 0;
  - (c) `hold_q` != 0 and `cnt` == `hold_q` - 1.
- On that release edge:
  - `grant` = 0, `busy` = 0, `rel_pulse` = 1.
  - `rel_cause` takes the highest-priority true condition, in order (a) > (b) > (c).
- `rel_pulse` is 0 on every other cycle.
- `done` and changes to `hold_len` are ignored while in IDLE.
- `req` bits other than `req[sel]` have no effect during GRANT.
- `dout` updates each edge: `din[sel_next]` if the next state is GRANT, else 0.
- Reset values (asynchronous, on `rst_n` low):
  - State IDLE; `grant` = 0; `sel` = 0; `busy` = 0; `dout` = 0; `rel_pulse` = 0; `rel_cause` = 00; `cnt` = 0; `hold_q` = 0.
  - `ptr` = 3, so requester 0 has first priority after reset.
- Reset during GRANT aborts the grant immediately: no `rel_pulse` and no `rel_cause` update.

## Timing
- Request-to-grant latency is 1 cycle: `req` high before edge t means `grant` is valid after edge t.
- With `hold_len` = H > 0 and no `done` or request drop, `grant` is high for exactly H cycles.
- Minimum gap between grants is 1 idle cycle, so `grant` never goes directly from one requester to another.
- `done` sampled high at an edge ends the grant at that same edge. The grant is therefore at least 1 cycle long; `hold_len` = 1 gives exactly 1 cycle.
- `dout` is aligned with `grant`: same-cycle validity, with `din` sampled at the previous edge.
- `hold_len` = 0 with a persistent request and no `done` keeps the grant indefinitely. `cnt` saturation does not trigger a release.
- `rel_pulse` and `busy` falling occur on the same edge.

## Test plan
- Reset with `req` = 1111 -> first grant is 0001 one cycle after `rst_n` rises. With `hold_len` = 2, the sequence is 0001 (2 cycles), 0000, 0010 (2 cycles), 0000, 0100, 0000, 1000, 0000, then back to 0001. `rel_cause` = 11 at each release.
- `req` = 0100 only, `hold_len` = 0, `done` pulsed 5 cycles after grant -> `grant` = 0100 for 5 cycles, then `rel_pulse` = 1, `rel_cause` = 01, `grant` = 0, and a re-grant of 0100 after 1 idle cycle.
- Grant to requester 1, drop `req[1]` and assert `done` on the same cycle -> release on that edge with `rel_cause` = 01 (done outranks drop). Repeat with only the drop -> `rel_cause` = 10.
- `hold_len` = 3 and `done` asserted at `cnt` = 2 simultaneously -> release after exactly 3 cycles with `rel_cause` = 01.
- `din` toggling while requester 2 is granted -> `dout` tracks `din[2]` one cycle delayed. `dout` = 0 during idle cycles regardless of `din`.
- Assert `rst_n` low mid-grant -> all outputs are at reset values asynchronously and `rel_pulse` stays 0. After release from reset, requester 0 wins over 1, 2 and 3 with `req` = 1111.
